// File: rtl/i2c_codec_pkg.sv
// Shared constants for the codec register-interface I2C target:
// FSM encoding, bus address and the power-on register image.
package i2c_codec_pkg;

    localparam logic [6:0] CODEC_DEV_ADDR  = 7'h1A;
    localparam int         CODEC_NUM_REGS  = 10;
    localparam logic [6:0] CODEC_RESET_REG = 7'h0F;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ADDR      = 3'd1;
    localparam logic [2:0] S_SUB       = 3'd2;
    localparam logic [2:0] S_DATA      = 3'd3;
    localparam logic [2:0] S_WAIT_STOP = 3'd4;
    localparam logic [2:0] S_IGNORE    = 3'd5;

    // Index 0 is the rightmost entry (R0).
    localparam logic [9:0][8:0] REG_DEFAULTS = {
        9'h000, 9'h000, 9'h00A, 9'h09F, 9'h008,
        9'h00A, 9'h079, 9'h079, 9'h097, 9'h097
    };

    typedef struct packed {
        logic [6:0] addr;
        logic [8:0] data;
    } wr_rec_t;

    function automatic logic [8:0] reg_default(input int idx);
        if (idx >= 0 && idx < 10) begin
            return REG_DEFAULTS[idx[3:0]];
        end
        return '0;
    endfunction

endpackage

// File: rtl/i2c_codec_target_if.sv
// Shadow-register access bundle between the I2C target and its readers.
interface i2c_codec_target_if;

    logic [3:0] rd_addr;
    logic [8:0] rd_data;
    logic       wr_strobe;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic       codec_active;
    logic [7:0] nack_count;

    modport slave (
        input  rd_addr,
        output rd_data,
        output wr_strobe,
        output wr_addr,
        output wr_data,
        output codec_active,
        output nack_count
    );

    modport master (
        output rd_addr,
        input  rd_data,
        input  wr_strobe,
        input  wr_addr,
        input  wr_data,
        input  codec_active,
        input  nack_count
    );

endinterface

// File: rtl/i2c_bus_monitor.sv
// Oversamples SCL/SDA on the system clock and flags edges and
// START/STOP conditions from the synchronized samples.
module i2c_bus_monitor (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_q;
    logic       sda_q;
    logic       scl_s;

    // Idle bus is high, so reset to 1 to avoid phantom edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
            scl_q    <= scl_sync[1];
            sda_q    <= sda_sync[1];
        end
    end

    assign scl_s = scl_sync[1];
    assign sda_s = sda_sync[1];

    assign scl_rise = scl_s & ~scl_q;
    assign scl_fall = ~scl_s & scl_q;

    // SCL must be high in both samples, so an SCL edge wins.
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/i2c_codec_target.sv
// Write-only I2C target emulating the audio codec register port:
// 7-bit register index + 9-bit data, shadow register file readable locally.
module i2c_codec_target
    import i2c_codec_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = CODEC_DEV_ADDR,
    parameter int         NUM_REGS  = CODEC_NUM_REGS,
    parameter logic [6:0] RESET_REG = CODEC_RESET_REG
) (
    input  logic                CLOCK_50,
    input  logic                iRST_N,
    input  logic                I2C_SCLK,
    inout  wire                 I2C_SDAT,
    i2c_codec_target_if.slave   bus
);

    localparam int IW = $clog2(NUM_REGS);

    logic [1:0] rst_pipe;
    logic       rst_n;

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda_s;

    logic [2:0] state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       byte_full;
    logic       in_ack;
    logic       sda_oe;
    logic       shifting;
    logic [6:0] reg_idx;
    logic       d8;

    logic [8:0] regs [NUM_REGS];
    logic [8:0] rd_data;
    logic       wr_strobe;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic [7:0] nack_count;

    // Assert immediately, release on a clock edge.
    always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_n = rst_pipe[1];

    i2c_bus_monitor u_mon (
        .clk       (CLOCK_50),
        .rst_n     (rst_n),
        .scl       (I2C_SCLK),
        .sda       (I2C_SDAT),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    assign I2C_SDAT = sda_oe ? 1'b0 : 1'bz;

    assign shifting = !in_ack && !byte_full &&
                      (state == S_ADDR || state == S_SUB ||
                       state == S_DATA || state == S_WAIT_STOP);

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            bit_cnt    <= 3'd0;
            shreg      <= 8'h00;
            byte_full  <= 1'b0;
            in_ack     <= 1'b0;
            sda_oe     <= 1'b0;
            reg_idx    <= 7'd0;
            d8         <= 1'b0;
            wr_strobe  <= 1'b0;
            wr_addr    <= 7'd0;
            wr_data    <= 9'd0;
            nack_count <= 8'd0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= reg_default(i);
            end
        end else begin
            wr_strobe <= 1'b0;
            if (start_det) begin
                state     <= S_ADDR;
                bit_cnt   <= 3'd0;
                byte_full <= 1'b0;
                in_ack    <= 1'b0;
                sda_oe    <= 1'b0;
            end else if (stop_det) begin
                state     <= S_IDLE;
                bit_cnt   <= 3'd0;
                byte_full <= 1'b0;
                in_ack    <= 1'b0;
                sda_oe    <= 1'b0;
            end else if (scl_rise && shifting) begin
                shreg   <= {shreg[6:0], sda_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_full <= 1'b1;
                end
            end else if (scl_fall && in_ack) begin
                in_ack <= 1'b0;
                sda_oe <= 1'b0;
            end else if (scl_fall && byte_full) begin
                byte_full <= 1'b0;
                in_ack    <= 1'b1;
                unique case (state)
                    S_ADDR: begin
                        if (shreg == {DEV_ADDR, 1'b0}) begin
                            sda_oe <= 1'b1;
                            state  <= S_SUB;
                        end else begin
                            state <= S_IGNORE;
                            if (nack_count != 8'hFF) begin
                                nack_count <= nack_count + 8'd1;
                            end
                        end
                    end
                    S_SUB: begin
                        sda_oe  <= 1'b1;
                        reg_idx <= shreg[7:1];
                        d8      <= shreg[0];
                        state   <= S_DATA;
                    end
                    S_DATA: begin
                        sda_oe    <= 1'b1;
                        wr_strobe <= 1'b1;
                        wr_addr   <= reg_idx;
                        wr_data   <= {d8, shreg};
                        state     <= S_WAIT_STOP;
                        if (int'(reg_idx) < NUM_REGS) begin
                            regs[reg_idx[IW-1:0]] <= {d8, shreg};
                        end else if (reg_idx == RESET_REG) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                regs[i] <= reg_default(i);
                            end
                        end
                    end
                    S_WAIT_STOP: begin
                        if (nack_count != 8'hFF) begin
                            nack_count <= nack_count + 8'd1;
                        end
                    end
                    default: begin
                        in_ack <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 9'd0;
        end else if (int'(bus.rd_addr) < NUM_REGS) begin
            rd_data <= regs[bus.rd_addr[IW-1:0]];
        end else begin
            rd_data <= 9'd0;
        end
    end

    assign bus.rd_data      = rd_data;
    assign bus.wr_strobe    = wr_strobe;
    assign bus.wr_addr      = wr_addr;
    assign bus.wr_data      = wr_data;
    assign bus.codec_active = regs[9][0];
    assign bus.nack_count   = nack_count;

endmodule

// File: doc/i2c_codec_target.md
Name: i2c_codec_target

Overview:
- Synthesizable I2C write-only target that models the audio codec register interface (7-bit register address, 9-bit data) on the configuration bus.
- Used as an on-FPGA loopback or bench responder for the configuration master. It acknowledges the codec device address, decodes 3-byte write transactions and holds a shadow register file.
- The rest of the design (status LEDs, checkers) reads the shadow registers.
- SCL/SDA are oversampled on CLOCK_50. The block never drives SCL.

Parameters:
DEV_ADDR, 7'h1A, 7-bit target address; write byte on the wire is 8'h34.
NUM_REGS, 10, number of stored registers, indices 0..NUM_REGS-1.
RESET_REG, 7'h0F, register index whose write restores all defaults.

Ports:
CLOCK_50  in  1  system clock, 50 MHz.
iRST_N  in  1  asynchronous, active-low reset.
I2C_SCLK  in  1  bus clock, driven by the master.
I2C_SDAT  inout  1  open-drain data; the block drives only 0 (when sda_oe=1), otherwise Z.
rd_addr  in  4  shadow register read index.
rd_data  out  9  registered read data; 1-cycle latency; 0 for index >= NUM_REGS.
wr_strobe  out  1  1-cycle pulse when a register write commits.
wr_addr  out  7  register index of the last commit.
wr_data  out  9  data of the last commit.
codec_active  out  1  mirror of reg9 bit0.
nack_count  out  8  saturating count of NACKed bytes.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, sda_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, rd_data=0, nack_count=0.
  - Registers load defaults R0..R9 = 097, 097, 079, 079, 00A, 008, 09F, 00A, 000, 000 (hex).
  - codec_active=0.
- Input conditioning:
  - 2-FF synchronizer on SCL and SDA, plus one history flop each for edge detection.
  - All edges and conditions are evaluated on synchronized values.
- Bus conditions (both are valid in any state):
  - START: SDA falls while SCL high. Aborts any partial transaction with no write, clears the bit counter and goes to ADDR.
  - STOP: SDA rises while SCL high. Goes to IDLE, releases SDA, no write.
- Bit sampling and ACK timing:
  - Bits are sampled on the SCL rising edge, MSB first, using a 3-bit counter.
  - After the 8th bit, at the next SCL falling edge, enter ACK phase.
  - ACK: sda_oe=1 for one full SCL low/high period; release at the following SCL falling edge.
  - NACK: keep sda_oe=0 and increment nack_count, saturating at 255.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits, then:
    - byte[7:1]==DEV_ADDR and byte[0]==0: ACK, then SUB.
    - Otherwise, including read requests: NACK, then IGNORE.
  - SUB: shift 8 bits, then always ACK.
    - Latch reg_idx=byte[7:1] and d8=byte[0].
    - Next state DATA.
  - DATA: shift 8 bits, then always ACK.
    - The commit occurs in the CLOCK_50 cycle of the falling edge that starts the ACK.
    - Commit actions: wr_strobe=1, wr_addr=reg_idx, wr_data={d8, byte}.
    - Next state WAIT_STOP.
  - Commit rules by reg_idx:
    - reg_idx < NUM_REGS: register updated at the commit; rd_data reflects it from the next cycle on.
    - reg_idx == RESET_REG: all registers return to defaults, regardless of data.
    - Any other index: strobe only, no storage change.
  - WAIT_STOP: further data bytes are NACKed (counted) and not stored. A STOP or START ends the state.
  - IGNORE: SDA never driven; leave on STOP or START.
- Glitch and edge rules:
  - A START or STOP occurring during an ACK releases SDA immediately.
  - A simultaneous SCL edge and SDA change in the same synchronized sample: SCL takes priority, no START/STOP is inferred.
- Reset mid-transaction: SDA is released within the same cycle (async), and the partial byte is lost.
- codec_active updates in the same cycle as a reg9 write.

Decomposition:
- Shared package i2c_codec_pkg:
  - state encoding (IDLE, ADDR, SUB, DATA, WAIT_STOP, IGNORE);
  - default register values array;
  - DEV_ADDR / RESET_REG constants.
- One natural sub-module: i2c_bus_monitor. It contains the synchronizers and edge detection and outputs scl_rise, scl_fall, start_det, stop_det, sda_s.

Test Plan:
- Master writes bytes 34, 0E, 4D -> three ACKs; wr_strobe once with wr_addr=7, wr_data=04D; rd_addr=7 returns 04D; nack_count=0.
- Bytes 34, 12, 01 -> reg9=001, codec_active=1. Then bytes 34, 1E, 00 -> all registers back to defaults and codec_active=0.
- Address byte 40 followed by two bytes -> NACK on address, SDA never driven, no wr_strobe, nack_count=1.
- Bytes 34, 08, then repeated START before the data byte, then 34, 08, 79 -> exactly one wr_strobe with wr_addr=4, data=079.
- Bytes 34, 04, 7F, 55 (extra byte) -> reg2=07F, fourth byte NACKed, nack_count=1.
- iRST_N low during the ACK of the data byte -> SDA released immediately, no commit, registers at defaults.
